// File: rtl/inverter_selftest_if.sv
// Operand/result link between the self-test engine and one inverter instance.
`timescale 1ns/1ps

interface inverter_selftest_if;
  logic [7:0] dut_a;
  logic [7:0] dut_result;

  modport master (output dut_a, input dut_result);
  modport slave  (input dut_a, output dut_result);
endinterface

// File: rtl/inverter_selftest.sv
// On-chip stimulus/checker for an 8-bit bitwise inverter: drives a fixed+LFSR
// vector stream, samples the fed-back result after a settle window, logs errors.
`timescale 1ns/1ps

module inverter_selftest #(
  parameter int         NUM_VECTORS = 16,
  parameter int         SETTLE      = 1,
  parameter logic [7:0] SEED        = 8'hAD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  inverter_selftest_if.master        inv,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [7:0]                 err_count,
  output logic [7:0]                 first_fail_a,
  output logic [7:0]                 first_fail_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] IDX_LAST    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Galois right-shift LFSR, taps 8'hB8
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic [7:0] y;
    y = x >> 1;
    if (x[0]) begin
      y = y ^ 8'hB8;
    end else begin
      y = y;
    end
    return y;
  endfunction

  state_t     state_r;
  logic [7:0] dut_a_r;
  logic [7:0] idx_r;
  logic [3:0] settle_r;
  logic [7:0] lfsr_r;
  logic [7:0] err_count_r;
  logic [7:0] first_fail_a_r;
  logic [7:0] first_fail_result_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;

  logic       mismatch_s;
  logic [7:0] err_next_s;
  logic [7:0] next_vec_s;

  // Compare result, next error count and next vector in the stream
  always_comb begin
    mismatch_s = (inv.dut_result != ~dut_a_r);
    err_next_s = err_count_r + {7'd0, mismatch_s};
    next_vec_s = 8'h00;
    case (idx_r)
      8'd0:    next_vec_s = 8'hFF;
      8'd1:    next_vec_s = SEED;
      default: next_vec_s = lfsr_step(lfsr_r);
    endcase
  end

  // Run-control FSM with all outputs held in registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r             <= IDLE;
      dut_a_r             <= 8'h00;
      idx_r               <= 8'd0;
      settle_r            <= 4'd0;
      lfsr_r              <= 8'h00;
      err_count_r         <= 8'd0;
      first_fail_a_r      <= 8'h00;
      first_fail_result_r <= 8'h00;
      busy_r              <= 1'b0;
      done_r              <= 1'b0;
      pass_r              <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r             <= DRIVE;
            dut_a_r             <= 8'h00;
            idx_r               <= 8'd0;
            settle_r            <= 4'd0;
            lfsr_r              <= 8'h00;
            err_count_r         <= 8'd0;
            first_fail_a_r      <= 8'h00;
            first_fail_result_r <= 8'h00;
            busy_r              <= 1'b1;
            done_r              <= 1'b0;
            pass_r              <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          settle_r <= settle_r + 4'd1;
          if (settle_r == SETTLE_LAST) begin
            state_r <= CHECK;
          end else begin
            state_r <= DRIVE;
          end
        end
        CHECK: begin
          err_count_r <= err_next_s;
          // err_count still zero means this is the run's first mismatch
          if (mismatch_s && (err_count_r == 8'd0)) begin
            first_fail_a_r      <= dut_a_r;
            first_fail_result_r <= inv.dut_result;
          end else begin
            first_fail_a_r      <= first_fail_a_r;
            first_fail_result_r <= first_fail_result_r;
          end
          if (idx_r == IDX_LAST) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 8'd0);
          end else begin
            state_r  <= DRIVE;
            dut_a_r  <= next_vec_s;
            lfsr_r   <= next_vec_s;
            idx_r    <= idx_r + 8'd1;
            settle_r <= 4'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign inv.dut_a         = dut_a_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign pass              = pass_r;
  assign err_count         = err_count_r;
  assign first_fail_a      = first_fail_a_r;
  assign first_fail_result = first_fail_result_r;

endmodule

// File: tb/tb_inverter_selftest.sv
// Bench for inverter_selftest: faulty/correct/pipelined inverter models around
// three engine instances, scenario table plus reset/start corner sequences.
`timescale 1ns/1ps

module tb_inverter_selftest;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start3 = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] fault = 2'd0;

  int total = 0;
  int bad   = 0;

  inverter_selftest_if bus0();
  inverter_selftest_if bus3();
  inverter_selftest_if bus1();

  logic       busy0, done0, pass0, busy3, done3, pass3, busy1, done1, pass1;
  logic [7:0] err0, ffa0, ffr0, err3, ffa3, ffr3, err1, ffa1, ffr1;
  logic [7:0] p3a, p3b, p1a, p1b;

  // 0: correct, 1: pass-through, 2: result forced to 00 when operand is EE
  function automatic logic [7:0] fault_model(input logic [7:0] a, input logic [1:0] m);
    case (m)
      2'd1:    return a;
      2'd2:    return (a == 8'hEE) ? 8'h00 : ~a;
      default: return ~a;
    endcase
  endfunction

  assign bus0.dut_result = fault_model(bus0.dut_a, fault);

  // Two-cycle registered inverters for the settle-window instances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p3a <= 8'h00; p3b <= 8'h00; p1a <= 8'h00; p1b <= 8'h00;
    end else begin
      p3a <= ~bus3.dut_a; p3b <= p3a;
      p1a <= ~bus1.dut_a; p1b <= p1a;
    end
  end
  assign bus3.dut_result = p3b;
  assign bus1.dut_result = p1b;

  inverter_selftest u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .inv(bus0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_a(ffa0), .first_fail_result(ffr0));

  inverter_selftest #(.NUM_VECTORS(16), .SETTLE(3), .SEED(8'hAD)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .inv(bus3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_a(ffa3), .first_fail_result(ffr3));

  inverter_selftest #(.NUM_VECTORS(16), .SETTLE(1), .SEED(8'hAD)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .inv(bus1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_a(ffa1), .first_fail_result(ffr1));

  typedef struct {
    logic [1:0] mode;
    bit         do_reset;
    bit         mid_start;
    logic [7:0] exp_err;
    logic       exp_pass;
    logic [7:0] exp_ffa;
    logic [7:0] exp_ffr;
  } scen_t;

  scen_t      tbl[6];
  logic [7:0] exp_q[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_lfsr(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  task automatic push_vectors();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      v = 8'h00;
      else if (i == 1) v = 8'hFF;
      else if (i == 2) v = 8'hAD;
      else             v = model_lfsr(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check8("rst_busy", {7'd0, busy0}, 8'd0);
    check8("rst_done_pass", {6'd0, done0, pass0}, 8'd0);
    check8("rst_err", err0, 8'd0);
    check8("rst_dut_a", bus0.dut_a, 8'h00);
    check8("rst_ff", ffa0 | ffr0, 8'h00);
  endtask

  task automatic run0(input scen_t t);
    int         cnt;
    logic [7:0] e;
    fault = t.mode;
    if (t.do_reset) do_reset();
    exp_q.delete();
    push_vectors();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check8("start_busy_done", {6'd0, busy0, done0}, 8'b10);
    check8("start_clear_err", err0, 8'd0);
    check8("start_clear_ffa", ffa0, 8'h00);
    check8("start_clear_ffr", ffr0, 8'h00);
    cnt = 0;
    while (busy0 && cnt < 2000) begin
      if (cnt % 2 == 0) begin
        if (exp_q.size() == 0) begin
          check_int("sb_underflow", cnt, -1);
        end else begin
          e = exp_q.pop_front();
          check8("dut_a_seq", bus0.dut_a, e);
        end
      end
      if (t.mid_start) start0 = (cnt == 9);
      @(negedge clk);
      cnt++;
    end
    start0 = 1'b0;
    check_int("busy_len", cnt, 32);
    check_int("sb_leftover", exp_q.size(), 0);
    check8("end_busy_done", {6'd0, busy0, done0}, 8'b01);
    check8("end_err", err0, t.exp_err);
    check8("end_pass", {7'd0, pass0}, {7'd0, t.exp_pass});
    check8("end_ffa", ffa0, t.exp_ffa);
    check8("end_ffr", ffr0, t.exp_ffr);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{2'd0, 1'b1, 1'b0, 8'd0,  1'b1, 8'h00, 8'h00};
    tbl[1] = '{2'd1, 1'b1, 1'b0, 8'd16, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{2'd0, 1'b0, 1'b0, 8'd0,  1'b1, 8'h00, 8'h00};
    tbl[3] = '{2'd2, 1'b1, 1'b0, 8'd1,  1'b0, 8'hEE, 8'h00};
    tbl[4] = '{2'd0, 1'b0, 1'b0, 8'd0,  1'b1, 8'h00, 8'h00};
    tbl[5] = '{2'd1, 1'b1, 1'b1, 8'd16, 1'b0, 8'h00, 8'h00};

    for (int i = 0; i < 6; i++) run0(tbl[i]);

    // Reset asserted for one cycle during vector 5 of a failing run
    fault = 2'd1;
    do_reset();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 11) begin
      @(negedge clk);
      cnt++;
    end
    check8("mid_err_nonzero", {7'd0, err0 != 8'd0}, 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check8("abort_busy_done_pass", {5'd0, busy0, done0, pass0}, 8'd0);
    check8("abort_err", err0, 8'd0);
    check8("abort_dut_a", bus0.dut_a, 8'h00);
    check8("abort_ffa", ffa0, 8'h00);
    check8("abort_ffr", ffr0, 8'h00);
    repeat (3) @(negedge clk);
    check8("abort_stays_idle", {7'd0, busy0}, 8'd0);

    // Reset wins over start on the same edge
    rst_n = 1'b0; start0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start0 = 1'b0;
    check8("rst_over_start", {6'd0, busy0, done0}, 8'd0);

    // SETTLE=3 with two-cycle inverter: must pass, 64 busy cycles
    do_reset();
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    cnt = 0;
    while (busy3 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check_int("s3_busy_len", cnt, 64);
    check8("s3_done_pass", {6'd0, done3, pass3}, 8'b11);
    check8("s3_err", err3, 8'd0);

    // SETTLE=1 with the same model samples too early
    do_reset();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check_int("s1_busy_len", cnt, 32);
    check8("s1_done_pass", {6'd0, done1, pass1}, 8'b10);
    check8("s1_err_nonzero", {7'd0, err1 != 8'd0}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inverter_selftest.md
Name: inverter_selftest

Overview:
- Self-checking stimulus generator and response checker for the 8-bit bitwise inverter datapath.
- Sits on the driving side of the inverter interface: drives the operand `dut_a`, waits a settle interval, samples `dut_result` and checks it equals `~dut_a`.
- Reports pass/fail, the error count, and the first failing vector.
- Used for on-chip bring-up and regression of inverter instances without a simulator bench.

Parameters:
- `NUM_VECTORS`, 16, number of vectors applied per run; legal range 3..255.
- `SETTLE`, 1, cycles `dut_a` is held before `dut_result` is sampled; legal range 1..15.
- `SEED`, 8'hAD, LFSR seed and third vector; must be nonzero.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `start`  input  1  begin a run; sampled only in IDLE or DONE.
- `dut_a`  output  8  operand driven to the inverter under test.
- `dut_result`  input  8  inverter output fed back.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  high while in DONE (level, not pulse).
- `pass`  output  1  `done` AND `err_count == 0`.
- `err_count`  output  8  number of mismatching vectors in the current or last run.
- `first_fail_a`  output  8  `dut_a` of the first mismatch; 0 if none.
- `first_fail_result`  output  8  `dut_result` sampled at the first mismatch; 0 if none.

Behaviour:
- Reset (`rst_n == 0` at a clock edge):
  - State goes to IDLE.
  - `dut_a`, `err_count`, `first_fail_a`, `first_fail_result`, vector index, settle counter and LFSR all clear to 0.
  - `busy`, `done` and `pass` go to 0.
  - Reset overrides every other input, including `start` in the same cycle, and aborts a run in progress.
- Vector sequence:
  - v0 = 8'h00, v1 = 8'hFF, v2 = `SEED`.
  - v(n+1) for n ≥ 2 comes from a Galois right-shift LFSR: if bit0 = 1, next = (x>>1) ^ 8'hB8; otherwise next = x>>1.
  - With the default seed the sequence is 00, FF, AD, EE, 77, ...
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - `start` = 1 goes to DRIVE next cycle.
  - On that edge: `dut_a` <= v0, index <= 0, settle counter <= 0, `err_count` and both `first_fail` registers <= 0.
  - `busy` = 1 from the following cycle.
- DRIVE:
  - `dut_a` is held constant and the settle counter increments each cycle.
  - Exit to CHECK once the counter reaches `SETTLE` - 1, so DRIVE lasts exactly `SETTLE` cycles.
- CHECK (one cycle):
  - Compare `dut_result` with `~dut_a`.
  - On mismatch, `err_count` += 1 (no overflow possible, since `NUM_VECTORS` ≤ 255).
  - If this is the first mismatch of the run, capture `first_fail_a` and `first_fail_result`.
  - If index == `NUM_VECTORS` - 1, go to DONE. Otherwise load the next vector into `dut_a`, index += 1, clear the settle counter and return to DRIVE.
- Timing:
  - Each vector occupies `SETTLE` + 1 cycles.
  - `busy` is high for exactly `NUM_VECTORS` × (`SETTLE` + 1) cycles.
  - `done` rises on the cycle `busy` falls.
- DONE:
  - `done` = 1; results and `dut_a` (last vector) are held.
  - `start` = 1 restarts the run exactly as from IDLE, with results cleared on the same edge.
- `start` while `busy` is ignored: no restart and no effect on counters.
- `dut_result` is sampled only in CHECK; its value in other states is don't-care.
- All outputs are registered; `pass` may be decoded from registered state.

Test Plan:
1. Correct inverter, defaults: reset, then pulse `start`.
   - Required: `dut_a` sequence 00, FF, AD, EE, 77, ...
   - `busy` high 32 cycles, then `done` = 1, `pass` = 1, `err_count` = 0, `first_fail_a` = 0, `first_fail_result` = 0.
2. Pass-through fault (`dut_result = dut_a`): run defaults.
   - Required: `err_count` = 16, `pass` = 0, `first_fail_a` = 00, `first_fail_result` = 00.
3. Single-vector fault (bench corrupts `dut_result` to 8'h00 only when `dut_a` == 8'hEE):
   - Required: `err_count` = 1, `first_fail_a` = EE, `first_fail_result` = 00, `pass` = 0.
4. `SETTLE` = 3 with a 2-cycle registered inverter model:
   - Required: `pass` = 1, `busy` high 64 cycles.
   - Repeat with `SETTLE` = 1 and the same model: `err_count` ≥ 1.
5. Reset and `start` interference: assert `rst_n` = 0 for one cycle during vector 5.
   - Required next cycle: IDLE, all outputs 0.
   - Separately, pulse `start` during `busy`: run length and results are unchanged.
6. Restart from DONE after the failing run of scenario 2, with a correct DUT:
   - Required: `err_count` and both `first_fail` registers clear on the `start` edge.
   - Final `pass` = 1.
